// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio PWM output path.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [SAMPLE_W-1:0]        level_t;

    localparam level_t LEVEL_MID = 8'd128;

    // Offset binary: flipping the sign bit maps -128..127 onto 0..255.
    function automatic level_t to_level(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample/control/output bundle between the sine generator side and audio_pwm_out.
interface audio_pwm_out_if;
    import audio_pkg::*;

    sample_t    sample_in;
    logic [2:0] vol_in;
    logic       mute_in;
    logic       step_out;
    level_t     level_out;
    logic       pwm_out;

    modport master (
        output sample_in, vol_in, mute_in,
        input  step_out, level_out, pwm_out
    );

    modport slave (
        input  sample_in, vol_in, mute_in,
        output step_out, level_out, pwm_out
    );

endinterface

// File: rtl/audio_pwm_core.sv
// Double-buffered 256-cycle PWM (or first-order sigma-delta when AUDIO_SDM_EN is defined).
module audio_pwm_core
    import audio_pkg::*;
(
    input  logic   clk_in,
    input  logic   rst_in,
    input  level_t pending_in,
    output logic   pwm_out,
    output level_t level_out
);

    logic [7:0] cnt_q;
    level_t     active_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q    <= '0;
            active_q <= LEVEL_MID;
        end else begin
            cnt_q <= cnt_q + 8'd1;
            // pending_in is the pre-edge value, so a same-edge capture plays next period.
            if (cnt_q == 8'hFF) begin
                active_q <= pending_in;
            end
        end
    end

    assign level_out = active_q;

`ifdef AUDIO_SDM_EN
    logic [8:0] acc_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[7:0]} + {1'b0, active_q};
        end
    end

    assign pwm_out = acc_q[8];
`else
    logic pwm_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (cnt_q < active_q);
        end
    end

    assign pwm_out = pwm_q;
`endif

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample-rate step strobe, delayed capture with volume/mute, PWM core.
// Define AUDIO_SDM_EN to swap the PWM comparator for a sigma-delta modulator.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int unsigned CLK_PER_SAMPLE = 8333,
    parameter int unsigned CAPTURE_DELAY  = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    audio_pwm_out_if.slave bus
);

    localparam int unsigned CntW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_SAMPLE - 1);

    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     step_q;
    logic [CAPTURE_DELAY-1:0] dly_q;
    level_t                   pending_q, pending_d;
    sample_t                  scaled;

    always_comb begin
        cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        scaled = bus.sample_in >>> bus.vol_in;
        if (bus.mute_in) begin
            scaled = '0;
        end
        pending_d = dly_q[CAPTURE_DELAY-1] ? to_level(scaled) : pending_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            step_q    <= 1'b0;
            dly_q     <= '0;
            pending_q <= LEVEL_MID;
        end else begin
            cnt_q     <= cnt_d;
            step_q    <= (cnt_q == CntLast);
            // Tap lines up with the generator's phase register plus registered LUT.
            dly_q[0]  <= step_q;
            for (int i = 1; i < int'(CAPTURE_DELAY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            pending_q <= pending_d;
        end
    end

    assign bus.step_out = step_q;

    audio_pwm_core u_core (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .pending_in (pending_q),
        .pwm_out    (bus.pwm_out),
        .level_out  (bus.level_out)
    );

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: vector table with a level scoreboard plus corner sequences.
module tb_audio_pwm_out;
    import audio_pkg::*;

    localparam int CPS   = 16;
    localparam int CPS_B = 253;  // first capture lands on the first PWM reload edge
    localparam int DLY   = 2;
    localparam int NVec  = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_pwm_out_if bus_a ();
    audio_pwm_out_if bus_b ();

    audio_pwm_out #(.CLK_PER_SAMPLE(CPS), .CAPTURE_DELAY(DLY)) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_a)
    );

    audio_pwm_out #(.CLK_PER_SAMPLE(CPS_B), .CAPTURE_DELAY(DLY)) u_dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_b)
    );

    typedef struct {
        logic [7:0] sample;
        logic [2:0] vol;
        logic       mute;
        int         win;    // 0: hold sample; n: sample only in cycle step+n, else 0
        logic [7:0] level;
    } vec_t;

    vec_t   vecs[NVec];
    level_t exp_q[$];
    int     b_exp[3];
    int     checks = 0;
    int     errors = 0;
    int     edge_n = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    // Expected pwm bit after edge e (e >= 1) following reset release at level 128.
    function automatic logic exp_pwm_mid(input int e);
`ifdef AUDIO_SDM_EN
        return (e % 2) == 0;
`else
        return ((e - 1) % 256) < 128;
`endif
    endfunction

    initial begin
        vecs[0]  = '{8'h7F, 3'd0, 1'b0, 0, 8'd255};
        vecs[1]  = '{8'h80, 3'd0, 1'b0, 0, 8'd0};
        vecs[2]  = '{8'h80, 3'd3, 1'b0, 0, 8'd112};
        vecs[3]  = '{8'h7F, 3'd7, 1'b0, 0, 8'd128};
        vecs[4]  = '{8'h40, 3'd0, 1'b1, 0, 8'd128};
        vecs[5]  = '{8'h80, 3'd0, 1'b1, 0, 8'd128};
        vecs[6]  = '{8'h40, 3'd0, 1'b0, 2, 8'd192};
        vecs[7]  = '{8'h40, 3'd0, 1'b0, 1, 8'd128};
        vecs[8]  = '{8'h40, 3'd0, 1'b0, 3, 8'd128};
        vecs[9]  = '{8'hC0, 3'd0, 1'b0, 0, 8'd64};
        vecs[10] = '{8'hFF, 3'd1, 1'b0, 0, 8'd127};
        vecs[11] = '{8'h64, 3'd2, 1'b0, 0, 8'd153};
        vecs[12] = '{8'h7F, 3'd0, 1'b0, 0, 8'd255};
        b_exp    = '{128, 128, 255};

        bus_a.sample_in = 8'h00;
        bus_a.vol_in    = 3'd0;
        bus_a.mute_in   = 1'b0;
        bus_b.sample_in = 8'h7F;
        bus_b.vol_in    = 3'd0;
        bus_b.mute_in   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_step", int'(bus_a.step_out), 0);
        check("reset_pwm", int'(bus_a.pwm_out), 0);
        check("reset_level", int'(bus_a.level_out), 128);
        check("reset_level_b", int'(bus_b.level_out), 128);

        rst    = 1'b0;
        edge_n = 0;
        exp_q.push_back(LEVEL_MID);

        for (int p = 0; p <= NVec; p++) begin
            level_t exp_lvl;
            int     hi, hi_b, step_bad, pairs11, pairs_eq;
            logic   prev;
            exp_lvl = exp_q.pop_front();
            if (p < NVec) begin
                bus_a.vol_in    = vecs[p].vol;
                bus_a.mute_in   = vecs[p].mute;
                bus_a.sample_in = (vecs[p].win == 0) ? vecs[p].sample : 8'h00;
                exp_q.push_back(vecs[p].level);
            end
            hi = 0; hi_b = 0; step_bad = 0; pairs11 = 0; pairs_eq = 0; prev = 1'b0;
            for (int k = 0; k < 256; k++) begin
                if (p < NVec && vecs[p].win != 0) begin
                    bus_a.sample_in = ((edge_n % CPS) == vecs[p].win) ? vecs[p].sample : 8'h00;
                end
                tick();
                if (k == 0) begin
                    check("level_out", int'(bus_a.level_out), int'(exp_lvl));
                    if (p <= 2) check("level_out_b", int'(bus_b.level_out), b_exp[p]);
                end
                if (bus_a.step_out !== ((edge_n % CPS) == 0)) step_bad++;
                if (k > 0 && prev && bus_a.pwm_out) pairs11++;
                if (k > 0 && prev == bus_a.pwm_out) pairs_eq++;
                prev = bus_a.pwm_out;
                hi   += int'(bus_a.pwm_out);
                hi_b += int'(bus_b.pwm_out);
            end
            check("pwm_high_count", hi, int'(exp_lvl));
            check("step_pattern", step_bad, 0);
            if (p <= 2) check("pwm_high_count_b", hi_b, b_exp[p]);
`ifdef AUDIO_SDM_EN
            if (exp_lvl == 8'd64) check("sdm_adjacent_ones", pairs11, 0);
            if (exp_lvl == 8'd128) check("sdm_alternating", pairs_eq, 0);
`endif
        end

        // Level 255 still playing; reset at PWM count 100.
        repeat (100) tick();
        check("pre_reset_pwm", int'(bus_a.pwm_out), 1);
        check("pre_reset_level", int'(bus_a.level_out), 255);
        rst = 1'b1;
        tick();
        check("midreset_pwm", int'(bus_a.pwm_out), 0);
        check("midreset_level", int'(bus_a.level_out), 128);
        check("midreset_step", int'(bus_a.step_out), 0);
        rst    = 1'b0;
        edge_n = 0;
        begin
            int step_bad, pwm_bad;
            step_bad = 0; pwm_bad = 0;
            for (int k = 0; k < 256; k++) begin
                tick();
                if (k == 0) check("post_reset_first_pwm", int'(bus_a.pwm_out), int'(exp_pwm_mid(1)));
                if (bus_a.step_out !== ((edge_n % CPS) == 0)) step_bad++;
                if (bus_a.pwm_out !== exp_pwm_mid(edge_n)) pwm_bad++;
            end
            check("post_reset_step_pattern", step_bad, 0);
            check("post_reset_pwm_pattern", pwm_bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
